// File: rtl/imem_pkg.sv
// Shared types and constants for the banked instruction memory loader.
// Holds the controller state encoding and the NOP fill word.
package imem_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        LOAD  = 2'd2
    } state_t;

    localparam int unsigned NOP = 0;

endpackage

// File: rtl/imem_load_seq.sv
// Controller for the instruction memory: CLEAR sweep, RUN, and LOAD sequencing.
// Owns the shared clear/load word index and produces write strobes for the top.
module imem_load_seq
    import imem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_start,
    input  logic [IW-1:0] load_base_idx,
    input  logic          load_valid,
    input  logic          load_done,
    output state_t        state,
    output logic          wr_en,
    output logic          wr_load,
    output logic [IW-1:0] wr_idx
);

    state_t        state_d;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] idx_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            idx_q <= '0;
        end else begin
            state <= state_d;
            idx_q <= idx_d;
        end
    end

    always_comb begin
        state_d = state;
        idx_d   = idx_q;
        wr_en   = 1'b0;
        wr_load = 1'b0;
        wr_idx  = idx_q;
        unique case (state)
            CLEAR: begin
                wr_en = 1'b1;
                idx_d = idx_q + IW'(1);
                if (idx_q == IW'(DEPTH - 1)) begin
                    state_d = RUN;
                    idx_d   = '0;
                end
            end
            RUN: begin
                if (load_start) begin
                    state_d = LOAD;
                    idx_d   = load_base_idx;
                end
            end
            LOAD: begin
                // Index is IW bits wide, so the increment wraps modulo DEPTH.
                if (load_valid) begin
                    wr_en   = 1'b1;
                    wr_load = 1'b1;
                    idx_d   = idx_q + IW'(1);
                end
                if (load_done) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = CLEAR;
                idx_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/imem_banked_loader.sv
// Instruction memory with clear-on-reset, streaming program load and 1-cycle fetch.
// Define IMEM_PARITY_EN to store and check an even-parity bit per word.
module imem_banked_loader
    import imem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_done,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] instr,
    output logic              fetch_fault,
    output logic              busy
);

    localparam int IW = $clog2(DEPTH);
`ifdef IMEM_PARITY_EN
    localparam int MW = DATA_W + 1;
`else
    localparam int MW = DATA_W;
`endif
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(4 * DEPTH);

    state_t        state;
    logic          wr_en;
    logic          wr_load;
    logic [IW-1:0] wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic [MW-1:0] wr_word;
    logic [MW-1:0] rd_word;
    logic [MW-1:0] mem [DEPTH];
    logic          accept;
    logic          fault_c;
    logic          unused_base;

    assign unused_base = ^{load_base[ADDR_W-1:IW+2], load_base[1:0]};

    imem_load_seq #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_seq (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_start    (load_start),
        .load_base_idx (load_base[IW+1:2]),
        .load_valid    (load_valid),
        .load_done     (load_done),
        .state         (state),
        .wr_en         (wr_en),
        .wr_load       (wr_load),
        .wr_idx        (wr_idx)
    );

    assign fetch_ready = (state == RUN);
    assign busy        = (state != RUN);

    assign wr_data = wr_load ? load_data : DATA_W'(NOP);
`ifdef IMEM_PARITY_EN
    assign wr_word = {^wr_data, wr_data};
`else
    assign wr_word = wr_data;
`endif

    // Storage is deliberately not reset; CLEAR rewrites it after every reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_word;
        end
    end

    assign accept  = fetch_req & fetch_ready;
    assign rd_word = mem[fetch_addr[IW+1:2]];

    always_comb begin
        fault_c = (fetch_addr[1:0] != 2'b00) || (fetch_addr >= LIMIT);
`ifdef IMEM_PARITY_EN
        if (^rd_word) begin
            fault_c = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_valid <= 1'b0;
            fetch_fault <= 1'b0;
            instr       <= '0;
        end else begin
            fetch_valid <= accept;
            fetch_fault <= accept & fault_c;
            instr       <= (accept && !fault_c) ? rd_word[DATA_W-1:0] : '0;
        end
    end

endmodule
